// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receive path.
//   CLKS_PER_BIT_DEFAULT : default bit period in clk cycles (50 MHz / 115200)
//   rx_state_t / ST_*    : receiver state encoding
//   sticky_next()        : next value of a set-dominant sticky flag
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE      = 3'd0;
  localparam rx_state_t ST_START     = 3'd1;
  localparam rx_state_t ST_DATA      = 3'd2;
  localparam rx_state_t ST_STOP      = 3'd3;
  localparam rx_state_t ST_WAIT_HIGH = 3'd4;

  // A new set event always beats a clear arriving on the same cycle.
  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock FIFO with a registered head-of-queue output.
//   clk, rst_n       : clock, synchronous active-low reset
//   wr_en, wr_data   : push request and data
//   rd_en            : consumer ready; pops when rd_valid is also high
//   rd_data          : entry at the head (0 after reset)
//   rd_valid         : FIFO not empty
//   drop             : push refused because the FIFO was full with no pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             valid_r;
  logic [WIDTH-1:0] head_r;

  logic             do_push_s;
  logic             do_pop_s;
  logic             full_s;
  logic [AW-1:0]    rd_ptr_next_s;
  logic [CW-1:0]    count_next_s;
  logic [CW-1:0]    remaining_s;
  logic [WIDTH-1:0] head_next_s;

  // Push/pop qualification, next occupancy and next head entry.
  always_comb begin
    full_s        = (count_r == CNT_FULL);
    do_pop_s      = rd_en && valid_r;
    // A pop on the same cycle frees the slot a full FIFO needs.
    do_push_s     = wr_en && (!full_s || do_pop_s);
    drop          = wr_en && full_s && !do_pop_s;
    rd_ptr_next_s = do_pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    remaining_s   = do_pop_s ? (count_r - CNT_ONE) : count_r;
    count_next_s  = count_r;
    if (do_push_s && !do_pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (!do_push_s && do_pop_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
    // When nothing else remains, the byte being written becomes the head.
    if (do_push_s && (remaining_s == {CW{1'b0}})) begin
      head_next_s = wr_data;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Storage, pointers, occupancy and registered head/valid outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next_s;
      valid_r  <= (count_next_s != {CW{1'b0}});
      head_r   <= head_next_s;
    end
  end

  assign rd_data  = head_r;
  assign rd_valid = valid_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- 8N1 UART receiver feeding a small receive FIFO.
//   clk, rst_n           : clock, synchronous active-low reset
//   rxd                  : asynchronous serial input, idles high
//   out_data, out_valid  : FIFO head byte and not-empty flag
//   out_ready            : consumer accept (pop when out_valid is high)
//   rx_busy              : receiver is inside a frame (state not IDLE)
//   frame_err            : sticky, stop bit sampled low
//   overrun              : sticky, byte dropped because the FIFO was full
//   err_clr              : pulse clearing both sticky flags
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          sync1_r;
  logic          rxs_r;
  rx_state_t     state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          busy_r;
  logic          frame_err_r;
  logic          overrun_r;

  rx_state_t     state_next_s;
  logic [CW-1:0] cnt_next_s;
  logic [2:0]    bit_cnt_next_s;
  logic [7:0]    shift_next_s;
  logic          push_s;
  logic          ferr_set_s;
  logic          drop_s;

  // Receiver FSM: next state, bit timing counter and shift register.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    bit_cnt_next_s = bit_cnt_r;
    shift_next_s   = shift_r;
    push_s         = 1'b0;
    ferr_set_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          state_next_s = ST_START;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt_r == HALF_LAST) begin
          cnt_next_s     = CNT_ZERO;
          bit_cnt_next_s = 3'd0;
          if (rxs_r) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          // LSB arrives first, so new bits enter at the top.
          shift_next_s = {rxs_r, shift_r[7:1]};
          cnt_next_s   = CNT_ZERO;
          if (bit_cnt_r == 3'd7) begin
            state_next_s = ST_STOP;
          end else begin
            bit_cnt_next_s = bit_cnt_r + 3'd1;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_next_s = CNT_ZERO;
          if (rxs_r) begin
            push_s       = 1'b1;
            state_next_s = ST_IDLE;
          end else begin
            ferr_set_s   = 1'b1;
            state_next_s = ST_WAIT_HIGH;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_HIGH: begin
        // A held break must not be taken as a stream of new start bits.
        if (rxs_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // Input synchronizer, FSM registers, busy and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r     <= 1'b1;
      rxs_r       <= 1'b1;
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      sync1_r     <= rxd;
      rxs_r       <= sync1_r;
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      bit_cnt_r   <= bit_cnt_next_s;
      shift_r     <= shift_next_s;
      busy_r      <= (state_next_s != ST_IDLE);
      frame_err_r <= sticky_next(frame_err_r, ferr_set_s, err_clr);
      overrun_r   <= sticky_next(overrun_r, drop_s, err_clr);
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (push_s),
    .wr_data  (shift_r),
    .rd_en    (out_ready),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .drop     (drop_s)
  );

  assign rx_busy   = busy_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo -- directed bench for uart_rx_fifo (CLKS_PER_BIT=8, FIFO_DEPTH=4).
// A frame-level model predicts when each byte lands, which bytes the FIFO
// holds and the sticky flags; it is compared with the DUT every cycle.
module tb_uart_rx_fifo;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  // Cycles from driving the start edge to the stop-bit sample: two
  // synchronizer stages, one cycle to leave IDLE, half a bit to the middle
  // of the start bit, then nine full bits to the middle of the stop bit.
  localparam int FRAME_LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       err_clr = 1'b0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] data;
    logic       good;
  } ev_t;

  ev_t        ev[$];
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic       ferr_m = 1'b0;
  logic       ovr_m = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update at each rising edge, then compare #1 later.
  initial begin
    logic pop_m;
    logic set_f;
    logic set_o;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        ev.delete();
        ferr_m = 1'b0;
        ovr_m  = 1'b0;
      end else begin
        if (prev_valid && out_ready) got.push_back(prev_data);
        pop_m = (q.size() > 0) && out_ready;
        set_f = 1'b0;
        set_o = 1'b0;
        if (pop_m) void'(q.pop_front());
        while (ev.size() > 0 && ev[0].at <= cyc) begin
          if (ev[0].at == cyc) begin
            if (!ev[0].good) set_f = 1'b1;
            else if (q.size() < DEPTH) q.push_back(ev[0].data);
            else set_o = 1'b1;
          end
          void'(ev.pop_front());
        end
        ferr_m = set_f ? 1'b1 : (err_clr ? 1'b0 : ferr_m);
        ovr_m  = set_o ? 1'b1 : (err_clr ? 1'b0 : ovr_m);
      end
      #1;
      chk("valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk("data", {24'd0, out_data}, {24'd0, q[0]});
      chk("frame_err", {31'd0, frame_err}, {31'd0, ferr_m});
      chk("overrun", {31'd0, overrun}, {31'd0, ovr_m});
      prev_valid = out_valid;
      prev_data  = out_data;
    end
  end

  // All line/handshake drives happen on falling edges.
  task automatic line(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev.push_back('{cyc + FRAME_LAT, b, stop});
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(b[i], CPB);
    line(stop, CPB);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    int d;
    logic [7:0] exp33 [4];
    logic [7:0] exp34 [5];
    exp33 = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp34 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    @(negedge clk);
    line(1'b1, 3);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    line(1'b1, 5);

    // Single byte 0xA5 with the consumer always ready.
    got.delete();
    d = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_cyc(d + 4);
        chk("a5_busy_start", {31'd0, rx_busy}, 32'd1);
        wait_cyc(d + 78);
        chk("a5_valid_before", {31'd0, out_valid}, 32'd0);
        wait_cyc(d + 79);
        chk("a5_valid_at", {31'd0, out_valid}, 32'd1);
        chk("a5_busy_end", {31'd0, rx_busy}, 32'd0);
        wait_cyc(d + 80);
        chk("a5_valid_after", {31'd0, out_valid}, 32'd0);
      end
    join
    line(1'b1, 4);
    chk("a5_count", got.size(), 32'd1);
    if (got.size() == 1) chk("a5_byte", {24'd0, got[0]}, 32'hA5);

    // Two-cycle glitch must be rejected at mid start bit.
    d = cyc;
    line(1'b0, 2);
    rxd = 1'b1;
    wait_cyc(d + 4);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
    wait_cyc(d + 10);
    chk("glitch_idle", {31'd0, rx_busy}, 32'd0);
    line(1'b1, 90);
    chk("glitch_empty", {31'd0, out_valid}, 32'd0);

    // 0x3C with a low stop bit, then a held break; err_clr hits the set cycle.
    d = cyc;
    fork
      send_frame(8'h3C, 1'b0);
      begin
        wait_cyc(d + FRAME_LAT - 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
      end
    join
    line(1'b0, 19);
    chk("brk_ferr", {31'd0, frame_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    line(1'b0, 20);
    chk("brk_cleared", {31'd0, frame_err}, 32'd0);
    chk("brk_busy", {31'd0, rx_busy}, 32'd1);
    line(1'b1, 100);
    chk("brk_idle", {31'd0, rx_busy}, 32'd0);
    chk("brk_empty", {31'd0, out_valid}, 32'd0);

    // Consumer stalled: five bytes into a four-deep FIFO.
    out_ready = 1'b0;
    got.delete();
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1);
      line(1'b1, 2);
    end
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_head", {24'd0, out_data}, 32'h01);
    out_ready = 1'b1;
    line(1'b1, 10);
    chk("ovr_drain_n", got.size(), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("ovr_drain", {24'd0, got[i]}, {24'd0, exp33[i]});
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("ovr_clr", {31'd0, overrun}, 32'd0);

    // Full FIFO, pop coinciding with the push of 0x05.
    out_ready = 1'b0;
    got.delete();
    for (int b = 1; b <= 4; b++) begin
      send_frame(8'(b), 1'b1);
      line(1'b1, 2);
    end
    d = cyc;
    fork
      send_frame(8'h05, 1'b1);
      begin
        wait_cyc(d + FRAME_LAT - 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    line(1'b1, 2);
    chk("full_pop_ovr", {31'd0, overrun}, 32'd0);
    out_ready = 1'b1;
    line(1'b1, 10);
    chk("full_pop_n", got.size(), 32'd5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("full_pop", {24'd0, got[i]}, {24'd0, exp34[i]});

    // Reset during data bit 4 of 0xFF, then 0x5A.
    got.delete();
    d = cyc;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_cyc(d + 8 * 5 + 4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    line(1'b1, 4);
    send_frame(8'h5A, 1'b1);
    line(1'b1, 6);
    chk("rst_rx_n", got.size(), 32'd1);
    if (got.size() == 1) chk("rst_rx_byte", {24'd0, got[0]}, 32'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
